// File: rtl/stream_dsp_pkg.sv
// Shared definitions for the stream DSP blocks: Q-format limits, divider flags and pipeline latency.
// STREAM_DIVIDER_ROUND_EN adds one quotient bit for round-half-away-from-zero.
package stream_dsp_pkg;

`ifdef STREAM_DIVIDER_ROUND_EN
    localparam int ROUND_BITS = 1;
`else
    localparam int ROUND_BITS = 0;
`endif

    typedef struct packed {
        logic sat;
        logic div_zero;
        logic a_zero;
        logic a_neg;
    } div_flags_t;

    function automatic longint qmax(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

    function automatic longint qmin(input int w);
        return -(longint'(1) << (w - 1));
    endfunction

    // Input stage + one stage per quotient bit (W-1, plus the rounding bit) + output stage.
    function automatic int pipe_latency(input int w);
        return w + 1 + ROUND_BITS;
    endfunction

endpackage

// File: rtl/stream_divider_stage.sv
// One registered restoring-division iteration: resolves the next quotient bit, MSB first.
module stream_divider_stage
    import stream_dsp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] rem,
    input  logic [W-1:0] bmag,
    input  logic [W-1:0] quo,
    input  logic         sign,
    input  div_flags_t   flags,
    input  logic         valid,
    output logic [W-1:0] rem_reg,
    output logic [W-1:0] bmag_reg,
    output logic [W-1:0] quo_reg,
    output logic         sign_reg,
    output div_flags_t   flags_reg,
    output logic         valid_reg
);

    logic [W:0]   shifted;
    logic         take;
    logic [W-1:0] rem_next;
    logic [W-1:0] quo_next;

    // The remainder is always below |b| <= 2^(W-1), so the doubled value fits in W+1 bits.
    always_comb begin
        shifted  = {rem, 1'b0};
        take     = (shifted >= {1'b0, bmag});
        rem_next = take ? W'(shifted - {1'b0, bmag}) : W'(shifted);
        quo_next = W'({quo, take});
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_reg   <= '0;
            bmag_reg  <= '0;
            quo_reg   <= '0;
            sign_reg  <= 1'b0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            rem_reg   <= rem_next;
            bmag_reg  <= bmag;
            quo_reg   <= quo_next;
            sign_reg  <= sign;
            flags_reg <= flags;
            valid_reg <= valid;
        end
    end

endmodule

// File: rtl/stream_divider.sv
// Fully pipelined signed Q1.(W-1) divider, data_o = data_0 / data_1, one pair per cycle.
// STREAM_DIVIDER_ROUND_EN: round half away from zero with one extra pipeline stage.
module stream_divider
    import stream_dsp_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] data_0_i_tdata,
    input  logic                  data_0_i_tvalid,
    input  logic [DATA_WIDTH-1:0] data_1_i_tdata,
    input  logic                  data_1_i_tvalid,
    output logic [DATA_WIDTH-1:0] data_o_tdata,
    output logic                  data_o_tvalid
);

    localparam int W       = DATA_WIDTH;
    localparam int LATENCY = pipe_latency(W);
    localparam int NS      = LATENCY - 2;
    localparam logic [W-1:0] QMAX_V = W'(qmax(W));
    localparam logic [W-1:0] QMIN_V = W'(qmin(W));

    logic [W-1:0] a_mag, b_mag;
    div_flags_t   flags_next;

    logic [W-1:0] rem_reg, bmag_reg;
    logic         sign_reg, valid_reg;
    div_flags_t   flags_reg;

    logic [W-1:0] rem_s   [0:NS];
    logic [W-1:0] bmag_s  [0:NS];
    logic [W-1:0] quo_s   [0:NS];
    logic         sign_s  [0:NS];
    div_flags_t   flags_s [0:NS];
    logic         valid_s [0:NS];

    logic [W-1:0] q_mag;
    logic [W-1:0] data_next;

    always_comb begin
        a_mag = data_0_i_tdata[W-1] ? (~data_0_i_tdata + 1'b1) : data_0_i_tdata;
        b_mag = data_1_i_tdata[W-1] ? (~data_1_i_tdata + 1'b1) : data_1_i_tdata;
        flags_next.div_zero = (data_1_i_tdata == '0);
        flags_next.sat      = !flags_next.div_zero && (a_mag >= b_mag);
        flags_next.a_zero   = (data_0_i_tdata == '0);
        flags_next.a_neg    = data_0_i_tdata[W-1];
    end

    // Saturating/zero-divide cases start with a clean remainder; their quotient is ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rem_reg   <= '0;
            bmag_reg  <= '0;
            sign_reg  <= 1'b0;
            flags_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            rem_reg   <= (flags_next.sat || flags_next.div_zero) ? '0 : a_mag;
            bmag_reg  <= b_mag;
            sign_reg  <= data_0_i_tdata[W-1] ^ data_1_i_tdata[W-1];
            flags_reg <= flags_next;
            valid_reg <= data_0_i_tvalid & data_1_i_tvalid;
        end
    end

    assign rem_s[0]   = rem_reg;
    assign bmag_s[0]  = bmag_reg;
    assign quo_s[0]   = '0;
    assign sign_s[0]  = sign_reg;
    assign flags_s[0] = flags_reg;
    assign valid_s[0] = valid_reg;

    genvar gi;
    generate
        for (gi = 1; gi <= NS; gi++) begin : g_stage
            stream_divider_stage #(.W(W)) u_stage (
                .clk       (clk),
                .resetn    (resetn),
                .rem       (rem_s[gi-1]),
                .bmag      (bmag_s[gi-1]),
                .quo       (quo_s[gi-1]),
                .sign      (sign_s[gi-1]),
                .flags     (flags_s[gi-1]),
                .valid     (valid_s[gi-1]),
                .rem_reg   (rem_s[gi]),
                .bmag_reg  (bmag_s[gi]),
                .quo_reg   (quo_s[gi]),
                .sign_reg  (sign_s[gi]),
                .flags_reg (flags_s[gi]),
                .valid_reg (valid_s[gi])
            );
        end
    endgenerate

`ifdef STREAM_DIVIDER_ROUND_EN
    assign q_mag = {1'b0, quo_s[NS][W-1:1]} + {{(W-1){1'b0}}, quo_s[NS][0]};
`else
    assign q_mag = quo_s[NS];
`endif

    // A rounded magnitude of exactly 1.0 is not representable as positive and clamps like saturation.
    always_comb begin
        data_next = '0;
        if (flags_s[NS].div_zero) begin
            if (flags_s[NS].a_zero)
                data_next = '0;
            else
                data_next = flags_s[NS].a_neg ? QMIN_V : QMAX_V;
        end else if (flags_s[NS].sat || (q_mag == QMIN_V)) begin
            data_next = sign_s[NS] ? QMIN_V : QMAX_V;
        end else begin
            data_next = sign_s[NS] ? (~q_mag + 1'b1) : q_mag;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_o_tdata  <= '0;
            data_o_tvalid <= 1'b0;
        end else begin
            data_o_tdata  <= data_next;
            data_o_tvalid <= valid_s[NS];
        end
    end

endmodule

// File: tb/tb_stream_divider.sv
// Self-checking bench for stream_divider (DATA_WIDTH=16); honours STREAM_DIVIDER_ROUND_EN.
module tb_stream_divider;

`ifdef STREAM_DIVIDER_ROUND_EN
    localparam int          L     = 18;
    localparam logic [15:0] THIRD = 16'h2AAB;
`else
    localparam int          L     = 17;
    localparam logic [15:0] THIRD = 16'h2AAA;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] data_0_i_tdata = '0;
    logic        data_0_i_tvalid = 1'b0;
    logic [15:0] data_1_i_tdata = '0;
    logic        data_1_i_tvalid = 1'b0;
    logic [15:0] data_o_tdata;
    logic        data_o_tvalid;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic        hv [0:4095];
    logic        hs [0:4095];
    logic [15:0] hd [0:4095];

    stream_divider #(.DATA_WIDTH(16)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_0_i_tdata  (data_0_i_tdata),
        .data_0_i_tvalid (data_0_i_tvalid),
        .data_1_i_tdata  (data_1_i_tdata),
        .data_1_i_tvalid (data_1_i_tvalid),
        .data_o_tdata    (data_o_tdata),
        .data_o_tvalid   (data_o_tvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b);
        longint ia, ib, aa, bb, q;
        logic   neg;
        ia = longint'($signed(a));
        ib = longint'($signed(b));
        if (ib == 0) return (ia > 0) ? 16'h7FFF : ((ia < 0) ? 16'h8000 : 16'h0000);
        aa  = (ia < 0) ? -ia : ia;
        bb  = (ib < 0) ? -ib : ib;
        neg = (ia < 0) != (ib < 0);
        if (aa >= bb) return neg ? 16'h8000 : 16'h7FFF;
`ifdef STREAM_DIVIDER_ROUND_EN
        q = (((aa << 16) / bb) + 1) >> 1;
        if (q >= 32768) return neg ? 16'h8000 : 16'h7FFF;
`else
        q = (aa << 15) / bb;
`endif
        return neg ? 16'(-q) : 16'(q);
    endfunction

    // One clock: check the sample issued L cycles earlier, then drive the next one.
    task automatic cycle(input logic [15:0] a, input logic [15:0] b, input logic va,
                         input logic vb, input logic [15:0] e, input logic show);
        @(negedge clk);
        if (cyc >= L && hv[cyc-L]) begin
            check($sformatf("valid[%0d]", cyc - L), {31'd0, data_o_tvalid}, 32'd1);
            check($sformatf("data[%0d]", cyc - L), {16'd0, data_o_tdata}, {16'd0, hd[cyc-L]});
            if (hs[cyc-L])
                $display("txn %0d: out=%h exp=%h", cyc - L, data_o_tdata, hd[cyc-L]);
        end else begin
            check($sformatf("idle_valid[%0d]", cyc), {31'd0, data_o_tvalid}, 32'd0);
        end
        data_0_i_tdata  = a;
        data_1_i_tdata  = b;
        data_0_i_tvalid = va;
        data_1_i_tvalid = vb;
        hv[cyc] = va & vb;
        hd[cyc] = e;
        hs[cyc] = show;
        cyc++;
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        cycle(a, b, 1'b1, 1'b1, e, 1'b1);
        cycle(a, b, 1'b1, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic clear_history();
        for (int i = 0; i < cyc; i++) hv[i] = 1'b0;
    endtask

    logic [15:0] va_tab [0:13];
    logic [15:0] vb_tab [0:13];
    logic [15:0] ve_tab [0:13];

    initial begin
        logic [15:0] ra, rb;
        va_tab = '{16'h2000, 16'hE000, 16'h2000, 16'hE000, 16'h4000, 16'h8000, 16'h4000,
                   16'h1234, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000};
        vb_tab = '{16'h4000, 16'h4000, 16'hC000, 16'hC000, 16'h2000, 16'h8000, 16'hC000,
                   16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h4000, 16'h8001, 16'hC000};
        ve_tab = '{16'h4000, 16'hC000, 16'hC000, 16'h4000, 16'h7FFF, 16'h7FFF, 16'h8000,
                   16'h7FFF, 16'h0000, THIRD,    16'h8000, 16'h0000, 16'h8000, 16'h0000};

        #1;
        check("reset_valid", {31'd0, data_o_tvalid}, 32'd0);
        check("reset_data", {16'd0, data_o_tdata}, 32'd0);
        #22 resetn = 1'b1;

        for (int i = 0; i < 14; i++) directed(va_tab[i], vb_tab[i], ve_tab[i]);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 1) == 1) ra = $signed(ra) >>> $urandom_range(1, 8);
            cycle(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  model(ra, rb), 1'b0);
        end

        for (int i = 0; i < 20; i++) begin
            ra = $signed(16'($urandom)) >>> 2;
            rb = 16'($urandom) | 16'h4000;
            cycle(ra, rb, 1'b1, 1'b1, model(ra, rb), 1'b0);
        end
        #3 resetn = 1'b0;
        #1;
        check("async_reset_valid", {31'd0, data_o_tvalid}, 32'd0);
        check("async_reset_data", {16'd0, data_o_tdata}, 32'd0);
        clear_history();
        for (int i = 0; i < 3; i++) cycle(16'h1000, 16'h2000, 1'b1, 1'b1, 16'h4000, 1'b0);
        #8 resetn = 1'b1;
        clear_history();

        directed(16'h2000, 16'h4000, 16'h4000);
        directed(16'h0001, 16'h0003, THIRD);
        for (int i = 0; i < L + 3; i++) cycle(16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
